// File: rtl/pal_cfg_serializer.sv
// pal_cfg_serializer: feeds the PAL serial configuration port (CFG/EN) from a
// valid/ready byte stream. Words are shifted out LSB-first, one bit per clock,
// with EN_OUT high only on cycles that carry a configuration bit. DONE pulses
// once after CFG_BITS bits. Optional CRC-8 trailer check: define PAL_CFG_CRC_EN.
module pal_cfg_serializer #(
    parameter int CFG_BITS = 80,
    parameter int W        = 8
) (
    input  logic         CLK,
    input  logic         RES_N,
    input  logic [W-1:0] S_DATA,
    input  logic         S_VALID,
    output logic         S_READY,
    input  logic         ABORT,
    output logic         CFG_OUT,
    output logic         EN_OUT,
    output logic         BUSY,
    output logic         DONE
`ifdef PAL_CFG_CRC_EN
    ,
    output logic         CRC_ERR
`endif
);

    localparam int RW = $clog2(CFG_BITS + 1);
    localparam int BW = $clog2(W + 1);

`ifdef PAL_CFG_CRC_EN
    typedef enum logic [2:0] {IDLE, SHIFT, WAIT, CRC_WAIT, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, SHIFT, WAIT, FIN} state_t;
`endif

    state_t        state, state_nxt;
    logic [W-1:0]  shreg, shreg_nxt;
    logic [BW-1:0] word_bits, word_bits_nxt;
    logic [RW-1:0] remaining, remaining_nxt;
    logic          accept;
    logic          last_of_word;

`ifdef PAL_CFG_CRC_EN
    logic [7:0] crc, crc_nxt;
    logic       crc_err, crc_err_nxt;

    // CRC-8, poly 0x07, MSB-first, one serial bit per call
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign CRC_ERR = crc_err;
`endif

    // Number of bits to shift from a freshly loaded word: min(W, bits left)
    function automatic logic [BW-1:0] load_bits(input logic [RW-1:0] rem);
        if (rem > RW'(W))
            return BW'(W);
        else
            return BW'(rem);
    endfunction

    assign last_of_word = (word_bits == BW'(1)) && (remaining > RW'(1));

    // Ready is withheld during reset and abort so a word is never consumed then
    always_comb begin
        S_READY = 1'b0;
        case (state)
            IDLE, WAIT: S_READY = 1'b1;
            SHIFT:      S_READY = last_of_word;
`ifdef PAL_CFG_CRC_EN
            CRC_WAIT:   S_READY = 1'b1;
`endif
            default:    S_READY = 1'b0;
        endcase
        if (!RES_N || ABORT)
            S_READY = 1'b0;
    end

    assign accept = S_VALID & S_READY;

    // Next-state, datapath update and registered-state-derived outputs
    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        word_bits_nxt = word_bits;
        remaining_nxt = remaining;
        EN_OUT        = 1'b0;
        CFG_OUT       = 1'b0;
        DONE          = 1'b0;
        BUSY          = (state != IDLE);
`ifdef PAL_CFG_CRC_EN
        crc_nxt       = crc;
        crc_err_nxt   = crc_err;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_nxt     = S_DATA;
                    remaining_nxt = RW'(CFG_BITS);
                    word_bits_nxt = load_bits(RW'(CFG_BITS));
                    state_nxt     = SHIFT;
`ifdef PAL_CFG_CRC_EN
                    crc_nxt       = '0;
                    crc_err_nxt   = 1'b0;
`endif
                end
            end
            SHIFT: begin
                EN_OUT        = 1'b1;
                CFG_OUT       = shreg[0];
                shreg_nxt     = shreg >> 1;
                word_bits_nxt = word_bits - BW'(1);
                remaining_nxt = remaining - RW'(1);
`ifdef PAL_CFG_CRC_EN
                crc_nxt       = crc_step(crc, shreg[0]);
`endif
                if (remaining == RW'(1)) begin
`ifdef PAL_CFG_CRC_EN
                    state_nxt = CRC_WAIT;
`else
                    state_nxt = FIN;
`endif
                end else if (word_bits == BW'(1)) begin
                    // reload in the last-bit cycle keeps EN_OUT continuous
                    if (accept) begin
                        shreg_nxt     = S_DATA;
                        word_bits_nxt = load_bits(remaining - RW'(1));
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (accept) begin
                    shreg_nxt     = S_DATA;
                    word_bits_nxt = load_bits(remaining);
                    state_nxt     = SHIFT;
                end
            end
`ifdef PAL_CFG_CRC_EN
            CRC_WAIT: begin
                if (accept) begin
                    crc_err_nxt = (8'(S_DATA) != crc);
                    state_nxt   = FIN;
                end
            end
`endif
            FIN: begin
                DONE      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (ABORT) begin
            state_nxt     = IDLE;
            shreg_nxt     = '0;
            word_bits_nxt = '0;
            remaining_nxt = '0;
`ifdef PAL_CFG_CRC_EN
            crc_nxt       = '0;
            crc_err_nxt   = 1'b0;
`endif
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RES_N) begin
            state     <= IDLE;
            shreg     <= '0;
            word_bits <= '0;
            remaining <= '0;
`ifdef PAL_CFG_CRC_EN
            crc       <= '0;
            crc_err   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            word_bits <= word_bits_nxt;
            remaining <= remaining_nxt;
`ifdef PAL_CFG_CRC_EN
            crc       <= crc_nxt;
            crc_err   <= crc_err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_pal_cfg_serializer.sv
// Self-checking bench for pal_cfg_serializer: an 80-bit instance for full,
// gapped, random, abort and reset streams, and a 12-bit instance for the
// partial-last-word case. Expected bits come from the byte list, LSB-first.
module tb_pal_cfg_serializer;

    localparam int NB = 80;
    localparam int NW = 10;

    logic clk = 1'b0;
    logic res_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] a_data = '0;
    logic       a_valid = 1'b0, a_abort = 1'b0;
    logic       a_ready, a_cfg, a_en, a_busy, a_done;
    logic [7:0] b_data = '0;
    logic       b_valid = 1'b0, b_abort = 1'b0;
    logic       b_ready, b_cfg, b_en, b_busy, b_done;
`ifdef PAL_CFG_CRC_EN
    logic       a_crc_err, b_crc_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] words [NW];

    pal_cfg_serializer #(.CFG_BITS(NB), .W(8)) dut_a (
        .CLK(clk), .RES_N(res_n), .S_DATA(a_data), .S_VALID(a_valid),
        .S_READY(a_ready), .ABORT(a_abort), .CFG_OUT(a_cfg), .EN_OUT(a_en),
        .BUSY(a_busy), .DONE(a_done)
`ifdef PAL_CFG_CRC_EN
        , .CRC_ERR(a_crc_err)
`endif
    );

    pal_cfg_serializer #(.CFG_BITS(12), .W(8)) dut_b (
        .CLK(clk), .RES_N(res_n), .S_DATA(b_data), .S_VALID(b_valid),
        .S_READY(b_ready), .ABORT(b_abort), .CFG_OUT(b_cfg), .EN_OUT(b_en),
        .BUSY(b_busy), .DONE(b_done)
`ifdef PAL_CFG_CRC_EN
        , .CRC_ERR(b_crc_err)
`endif
    );

    task automatic test_reset();
        res_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({a_ready, a_en, a_cfg, a_busy, a_done} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_a: got %b expected 00000", {a_ready, a_en, a_cfg, a_busy, a_done});
        end
        n_cmp++;
        if ({b_ready, b_en, b_cfg, b_busy, b_done} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_b: got %b expected 00000", {b_ready, b_en, b_cfg, b_busy, b_done});
        end
        res_n = 1'b1;
        #1;
        n_cmp++;
        if ({a_ready, a_busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL release_ready: got ready/busy %b expected 10", {a_ready, a_busy});
        end
    endtask

    // Full stream on instance A. gap_word/gap_len: withhold S_VALID for gap_len
    // ready cycles once gap_word words were taken. exp_low<0 skips gap check.
    task automatic run_stream(input string name, input int gap_word, input int gap_len,
                              input bit rnd, input int exp_low);
        bit got[$];
        int widx = 0, gleft = gap_len, done_cnt = 0, low_inside = 0, low_run = 0;
        int cfg_bad = 0, tail = -1, seq_bad = 0, done_pos_bad = 0;
        bit seen_en = 1'b0;
        for (int cyc = 0; cyc < 600 && tail != 0; cyc++) begin
            @(posedge clk);
            #1;
            if (a_en) begin
                got.push_back(a_cfg);
                if (seen_en) low_inside += low_run;
                low_run = 0;
                seen_en = 1'b1;
            end else begin
                if (a_cfg) cfg_bad++;
                if (seen_en) low_run++;
            end
            if (a_done) begin
                done_cnt++;
                if (!(got.size() == NB && low_run == 1)) done_pos_bad++;
                tail = 3;
            end else if (tail > 0) begin
                tail--;
            end
            if (widx < NW) begin
                if (widx == gap_word && gleft > 0 && a_ready) begin
                    a_valid = 1'b0;
                    gleft--;
                end else begin
                    a_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                a_data = a_valid ? words[widx] : 8'($urandom);
            end else begin
                a_valid = 1'b0;
                a_data = 8'($urandom);
            end
            #1;
            if (a_valid && a_ready) widx++;
        end
        a_valid = 1'b0;
        for (int i = 0; i < got.size() && i < NB; i++)
            if (got[i] !== words[i / 8][i % 8]) seq_bad++;
        n_cmp++;
        if (got.size() != NB) begin
            n_bad++;
            $display("FAIL %s bit_count: got %0d expected %0d", name, got.size(), NB);
        end
        n_cmp++;
        if (seq_bad != 0) begin
            n_bad++;
            $display("FAIL %s bit_order: got %0d wrong bits expected 0", name, seq_bad);
        end
        n_cmp++;
        if (done_cnt != 1 || done_pos_bad != 0) begin
            n_bad++;
            $display("FAIL %s done: got %0d pulses (%0d misplaced) expected 1 right after last bit",
                     name, done_cnt, done_pos_bad);
        end
        n_cmp++;
        if (widx != NW) begin
            n_bad++;
            $display("FAIL %s words_taken: got %0d expected %0d", name, widx, NW);
        end
        n_cmp++;
        if (a_busy !== 1'b0 || cfg_bad != 0) begin
            n_bad++;
            $display("FAIL %s idle_out: got busy=%b cfg_when_en_low=%0d expected 0/0", name, a_busy, cfg_bad);
        end
        if (exp_low >= 0) begin
            n_cmp++;
            if (low_inside != exp_low) begin
                n_bad++;
                $display("FAIL %s en_gap: got %0d low cycles expected %0d", name, low_inside, exp_low);
            end
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < NW; i++) words[i] = 8'(i + 1);
        run_stream("full", -1, 0, 1'b0, 0);
    endtask

    task automatic test_gap();
        for (int i = 0; i < NW; i++) words[i] = 8'(i + 1);
        run_stream("gap", 4, 3, 1'b0, 3);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NW; i++) words[i] = 8'($urandom);
            run_stream("random", -1, 0, 1'b1, -1);
        end
    endtask

    // Abort (or one-cycle reset) while bit at_bit is on the line
    task automatic test_interrupt(input string name, input bit use_reset, input int at_bit);
        int cnt = 0, widx = 0, bad = 0;
        bit hit = 1'b0;
        for (int i = 0; i < NW; i++) words[i] = 8'($urandom);
        for (int cyc = 0; cyc < 400 && !hit; cyc++) begin
            @(posedge clk);
            #1;
            if (a_en) cnt++;
            a_valid = (widx < NW);
            a_data = words[(widx < NW) ? widx : NW - 1];
            if (a_en && cnt == at_bit) begin
                hit = 1'b1;
                if (use_reset) res_n = 1'b0;
                else a_abort = 1'b1;
                #1;
                n_cmp++;
                if (a_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s ready_during: got %b expected 0", name, a_ready);
                end
            end else begin
                #1;
                if (a_valid && a_ready) widx++;
            end
        end
        if (!hit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s reach_bit: got %0d bits expected to reach %0d", name, cnt, at_bit);
        end
        @(posedge clk);
        #1;
        res_n = 1'b1;
        a_abort = 1'b0;
        a_valid = 1'b0;
        #1;
        n_cmp++;
        if ({a_en, a_cfg, a_busy, a_done} !== 4'b0) begin
            n_bad++;
            $display("FAIL %s after: got en/cfg/busy/done %b expected 0000", name, {a_en, a_cfg, a_busy, a_done});
        end
        n_cmp++;
        if (a_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready_after: got %b expected 1", name, a_ready);
        end
        repeat (6) begin
            @(posedge clk);
            #1;
            if (a_en || a_done || a_busy) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s quiet: got %0d active cycles expected 0", name, bad);
        end
        for (int i = 0; i < NW; i++) words[i] = 8'($urandom);
        run_stream({name, "_fresh"}, -1, 0, 1'b0, 0);
    endtask

    // 12-bit instance: second word is partial, a third word must stay unconsumed
    task automatic test_partial();
        logic [7:0] bl [3];
        bit got[$];
        int bidx = 0, dc = 0, tail = -1, seq_bad = 0;
        bl[0] = 8'hFF;
        bl[1] = 8'hA5;
        bl[2] = 8'h33;
        for (int cyc = 0; cyc < 100 && tail != 0; cyc++) begin
            @(posedge clk);
            #1;
            if (b_en) got.push_back(b_cfg);
            if (b_done) begin
                dc++;
                tail = 4;
            end else if (tail > 0) begin
                tail--;
            end
            b_valid = (dc == 0);
            b_data = bl[(bidx < 3) ? bidx : 2];
            #1;
            if (b_valid && b_ready) bidx++;
        end
        b_valid = 1'b0;
        for (int i = 0; i < got.size() && i < 12; i++)
            if (got[i] !== bl[i / 8][i % 8]) seq_bad++;
        n_cmp++;
        if (got.size() != 12 || seq_bad != 0) begin
            n_bad++;
            $display("FAIL partial_bits: got %0d bits (%0d wrong) expected 12 (0 wrong)", got.size(), seq_bad);
        end
        n_cmp++;
        if (bidx != 2) begin
            n_bad++;
            $display("FAIL partial_words: got %0d expected 2", bidx);
        end
        n_cmp++;
        if (dc != 1 || b_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL partial_done: got done=%0d busy=%b expected 1/0", dc, b_busy);
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_partial();
        test_gap();
        test_interrupt("abort37", 1'b0, 37);
        test_interrupt("abort40", 1'b0, 40);
        test_interrupt("reset50", 1'b1, 50);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
